// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: one WIDTH/STAGES-bit slice per stage, valid/ready with global stall.
// Optional signed saturation on overflow when PIPELINED_ADDER_SAT_EN is defined.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    // Per-stage operands, partial result, inter-stage carry and valid bit
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] v_q, v_d;
    logic              ovf_q, ovf_d;
    logic              advance;

    // Whole pipeline moves together whenever the output slot is free or being drained
    assign advance  = !v_q[LAST] || out_ready;
    assign in_ready = advance;

    always_comb begin : stage_logic
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] r_src;
        logic             c_src;
        logic             v_src;
        logic [SLICE:0]   sum;
        a_src = '0;
        b_src = '0;
        r_src = '0;
        c_src = 1'b0;
        v_src = 1'b0;
        sum   = '0;
        ovf_d = 1'b0;
        c_d   = '0;
        v_d   = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            if (k == 0) begin
                a_src = a;
                b_src = b ^ {WIDTH{sub}};
                r_src = '0;
                c_src = sub | cin;
                v_src = in_valid;
            end else begin
                a_src = a_q[k-1];
                b_src = b_q[k-1];
                r_src = r_q[k-1];
                c_src = c_q[k-1];
                v_src = v_q[k-1];
            end
            sum = {1'b0, a_src[k*SLICE +: SLICE]} + {1'b0, b_src[k*SLICE +: SLICE]}
                + (SLICE+1)'(c_src);
            a_d[k] = a_src;
            b_d[k] = b_src;
            r_d[k] = r_src;
            r_d[k][k*SLICE +: SLICE] = sum[SLICE-1:0];
            c_d[k] = sum[SLICE];
            v_d[k] = v_src;
        end
        // Loop leaves the last stage's operands in a_src/b_src for the overflow test
        ovf_d = (a_src[WIDTH-1] == b_src[WIDTH-1]) && (r_d[LAST][WIDTH-1] != a_src[WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
        if (ovf_d) begin
            r_d[LAST] = a_src[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
            end
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign s         = r_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule
